r22sdf_twiddle_mul: RTL and testbench



---
 rtl/r22sdf_pkg.sv | 27 ++
 rtl/r22sdf_twiddle_mul_if.sv | 26 ++
 rtl/r22sdf_twiddle_addr_gen.sv | 42 ++++
 rtl/r22sdf_twiddle_mul.sv | 87 ++++++++
 tb/tb_r22sdf_twiddle_mul.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/r22sdf_pkg.sv
// Shared types and constants for the R2^2 SDF twiddle multiplier.
// Optional feature macro: R22SDF_TWMUL_SAT_EN (saturating output reduction).
package r22sdf_pkg;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 16;
  localparam int unsigned AW = 4;

  // Round-half-up constant for the Q1.(CW-1) product scaling
  localparam int unsigned RND_C = 1 << (CW - 2);

  localparam int SAT_MAX = (1 << (DW - 1)) - 1;
  localparam int SAT_MIN = -(1 << (DW - 1));

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } sample_t;

  typedef struct packed {
    logic signed [CW-1:0] re;
    logic signed [CW-1:0] im;
  } coef_t;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quarter_t;

endpackage

// File: rtl/r22sdf_twiddle_mul_if.sv
// Streaming sample, coefficient ROM and result bus of the twiddle multiplier.
interface r22sdf_twiddle_mul_if;
  import r22sdf_pkg::*;

  logic                 sync;
  logic                 din_valid;
  logic signed [DW-1:0] din_re;
  logic signed [DW-1:0] din_im;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_re;
  logic signed [CW-1:0] coef_im;
  logic                 dout_valid;
  logic signed [DW-1:0] dout_re;
  logic signed [DW-1:0] dout_im;

  modport master (
    output sync, din_valid, din_re, din_im, coef_re, coef_im,
    input  coef_addr, dout_valid, dout_re, dout_im
  );

  modport slave (
    input  sync, din_valid, din_re, din_im, coef_re, coef_im,
    output coef_addr, dout_valid, dout_re, dout_im
  );

endinterface

// File: rtl/r22sdf_twiddle_addr_gen.sv
// Frame sample index counter and R2^2 twiddle exponent mapping to ROM address.
module r22sdf_twiddle_addr_gen
  import r22sdf_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sync,
  input  logic          din_valid,
  output logic [AW-1:0] coef_addr
);

  localparam logic [AW-1:0] M_MASK = AW'((1 << (AW - 2)) - 1);

  logic [AW-1:0] cnt;
  logic [AW-1:0] n_eff;
  logic [AW-1:0] m;
  quarter_t      q;

  // Exponent e = 0, 2m, m, 3m per quarter; 3m stays below N
  always_comb begin
    n_eff     = (sync && din_valid) ? '0 : cnt;
    q         = quarter_t'(2'(n_eff >> (AW - 2)));
    m         = n_eff & M_MASK;
    coef_addr = '0;
    case (q)
      Q0:      coef_addr = '0;
      Q1:      coef_addr = m << 1;
      Q2:      coef_addr = m;
      Q3:      coef_addr = (m << 1) + m;
      default: coef_addr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (din_valid) begin
      cnt <= n_eff + AW'(1);
    end
  end

endmodule

// File: rtl/r22sdf_twiddle_mul.sv
// Streaming complex multiply by W_N^e = cos - j*sin, 3-cycle pipeline.
// Optional feature macro: R22SDF_TWMUL_SAT_EN (clamp instead of wrap on reduction).
module r22sdf_twiddle_mul
  import r22sdf_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  r22sdf_twiddle_mul_if.slave  bus
);

  localparam int unsigned PW = DW + CW;
  localparam int unsigned SW = PW + 1;
  localparam int unsigned RW = SW - (CW - 1);

  sample_t              s1_x;
  coef_t                s1_c;
  logic                 s1_valid;
  logic signed [PW-1:0] p_rc, p_is, p_ic, p_rs;
  logic                 s2_valid;
  sample_t              out_q;
  logic                 out_valid;

  logic signed [SW-1:0] rnd_re, rnd_im;
  logic signed [RW-1:0] sh_re, sh_im;

  r22sdf_twiddle_addr_gen u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync      (bus.sync),
    .din_valid (bus.din_valid),
    .coef_addr (bus.coef_addr)
  );

  function automatic logic signed [DW-1:0] reduce(input logic signed [RW-1:0] v);
`ifdef R22SDF_TWMUL_SAT_EN
    if (int'(v) > SAT_MAX)      reduce = DW'(SAT_MAX);
    else if (int'(v) < SAT_MIN) reduce = DW'(SAT_MIN);
    else                        reduce = DW'(v);
`else
    reduce = DW'(v);
`endif
  endfunction

  // Sum, round half up, scale back from Q1.(CW-1)
  always_comb begin
    rnd_re = SW'(p_rc) + SW'(p_is) + $signed(SW'(RND_C));
    rnd_im = SW'(p_ic) - SW'(p_rs) + $signed(SW'(RND_C));
    sh_re  = RW'(rnd_re >>> (CW - 1));
    sh_im  = RW'(rnd_im >>> (CW - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_x      <= '0;
      s1_c      <= '0;
      s1_valid  <= 1'b0;
      p_rc      <= '0;
      p_is      <= '0;
      p_ic      <= '0;
      p_rs      <= '0;
      s2_valid  <= 1'b0;
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      s1_x.re   <= bus.din_re;
      s1_x.im   <= bus.din_im;
      s1_c.re   <= bus.coef_re;
      s1_c.im   <= bus.coef_im;
      s1_valid  <= bus.din_valid;
      p_rc      <= PW'(s1_x.re) * PW'(s1_c.re);
      p_is      <= PW'(s1_x.im) * PW'(s1_c.im);
      p_ic      <= PW'(s1_x.im) * PW'(s1_c.re);
      p_rs      <= PW'(s1_x.re) * PW'(s1_c.im);
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_q.re <= reduce(sh_re);
        out_q.im <= reduce(sh_im);
      end
    end
  end

  assign bus.dout_valid = out_valid;
  assign bus.dout_re    = out_q.re;
  assign bus.dout_im    = out_q.im;

endmodule

// File: tb/tb_r22sdf_twiddle_mul.sv
// Directed, table-driven bench for r22sdf_twiddle_mul (address pattern, products, gaps, sync, reset).
module tb_r22sdf_twiddle_mul;
  import r22sdf_pkg::*;

  typedef struct {
    int                   n;
    logic signed [DW-1:0] xr, xi;
    logic signed [CW-1:0] cr, ci;
    logic [AW-1:0]        addr;
    logic signed [DW-1:0] er, ei;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  r22sdf_twiddle_mul_if bus();

  r22sdf_twiddle_mul dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic v,
                      input logic signed [DW-1:0] xr, input logic signed [DW-1:0] xi,
                      input logic signed [CW-1:0] cr, input logic signed [CW-1:0] ci);
    @(negedge clk);
    bus.sync      = s;
    bus.din_valid = v;
    bus.din_re    = xr;
    bus.din_im    = xi;
    bus.coef_re   = cr;
    bus.coef_im   = ci;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  vec_t vecs[7];
  logic [AW-1:0] addr_pat [16];

  initial begin
    addr_pat = '{0, 0, 0, 0, 0, 2, 4, 6, 0, 1, 2, 3, 0, 3, 6, 9};
    vecs[0] = '{0,      1000,      0, 32767,     0, 0,  1000,     0};
    vecs[1] = '{6,      1000,      0,     0, 32767, 4,     0, -1000};
`ifdef R22SDF_TWMUL_SAT_EN
    vecs[2] = '{5,    -32768, -32768, 23170, 23170, 2, -32768,    0};
`else
    vecs[2] = '{5,    -32768, -32768, 23170, 23170, 2,  19196,    0};
`endif
    vecs[3] = '{12,      100,   -200, 16384, -16384, 0,  150,   -50};
    vecs[4] = '{13,        3,      5, 32767, 32767, 3,     8,     2};
    vecs[5] = '{9,        -1,     -1, -32767,    0, 1,     1,     1};
    vecs[6] = '{1,         1,      0, 16384,     0, 0,     1,     0};

    rst_n         = 1'b0;
    bus.sync      = 1'b0;
    bus.din_valid = 1'b0;
    bus.din_re    = '0;
    bus.din_im    = '0;
    bus.coef_re   = '0;
    bus.coef_im   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_dout_valid", bus.dout_valid, 0);
    chk("reset_dout_re", bus.dout_re, 0);
    chk("reset_dout_im", bus.dout_im, 0);
    chk("reset_addr", bus.coef_addr, 0);
    rst_n = 1'b1;

    // Address pattern over one full frame plus the wrap
    for (int k = 0; k < 17; k++) begin
      step(k == 0, 1'b1, '0, '0, '0, '0);
      #1 chk($sformatf("addr_pat_%0d", k), bus.coef_addr, addr_pat[k % 16]);
    end
    repeat (4) idle();

    // Single-sample product vectors, each in its own sync-started frame
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k <= vecs[i].n; k++) begin
        if (k == vecs[i].n)
          step(k == 0, 1'b1, vecs[i].xr, vecs[i].xi, vecs[i].cr, vecs[i].ci);
        else
          step(k == 0, 1'b1, '0, '0, '0, '0);
      end
      #1 chk($sformatf("vec%0d_addr", i), bus.coef_addr, vecs[i].addr);
      idle();
      idle();
      if (vecs[i].n == 0) chk($sformatf("vec%0d_early", i), bus.dout_valid, 0);
      idle();
      chk($sformatf("vec%0d_valid", i), bus.dout_valid, 1);
      chk($sformatf("vec%0d_re", i), bus.dout_re, vecs[i].er);
      chk($sformatf("vec%0d_im", i), bus.dout_im, vecs[i].ei);
      idle();
      chk($sformatf("vec%0d_pulse", i), bus.dout_valid, 0);
      chk($sformatf("vec%0d_hold_re", i), bus.dout_re, vecs[i].er);
      chk($sformatf("vec%0d_hold_im", i), bus.dout_im, vecs[i].ei);
    end

    // Gaps hold the index; sync without valid is ignored; sync with valid restarts
    step(1'b1, 1'b1, '0, '0, '0, '0);
    step(1'b0, 1'b1, '0, '0, '0, '0);
    idle();
    step(1'b1, 1'b0, '0, '0, '0, '0);
    step(1'b0, 1'b1, '0, '0, '0, '0);
    #1 chk("gap_n2_addr", bus.coef_addr, 0);
    for (int k = 3; k < 9; k++) begin
      step(1'b0, 1'b1, '0, '0, '0, '0);
      #1 chk($sformatf("gap_n%0d_addr", k), bus.coef_addr, addr_pat[k]);
    end
    step(1'b1, 1'b1, '0, '0, '0, '0);
    #1 chk("sync_at_n9_addr", bus.coef_addr, 0);
    for (int k = 1; k < 6; k++) begin
      step(1'b0, 1'b1, '0, '0, '0, '0);
      #1 chk($sformatf("after_sync_n%0d_addr", k), bus.coef_addr, addr_pat[k]);
    end
    repeat (4) idle();

    // Mid-frame reset with two samples in flight
    step(1'b1, 1'b1, '0, '0, '0, '0);
    for (int k = 1; k < 4; k++) step(1'b0, 1'b1, '0, '0, '0, '0);
    step(1'b0, 1'b1, 500, 500, 32767, 0);
    step(1'b0, 1'b1, 700, -300, 32767, 0);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_valid_%0d", k), bus.dout_valid, 0);
      chk($sformatf("rst_re_%0d", k), bus.dout_re, 0);
      chk($sformatf("rst_im_%0d", k), bus.dout_im, 0);
      if (k < 2) idle();
    end
    step(1'b0, 1'b1, '0, '0, '0, '0);
    #1 chk("rst_next_addr", bus.coef_addr, 0);
    step(1'b0, 1'b1, '0, '0, '0, '0);
    #1 chk("rst_next2_addr", bus.coef_addr, 0);
    repeat (4) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
